// File: rtl/text_console.sv
// rtl/text_console.sv - byte-stream terminal writing glyph/attr cells into the 80x25 text buffer
// Define CONSOLE_ATTR_ESC_EN to enable the 0x1B <attr> attribute escape.
module text_console #(
  parameter logic [7:0] DEFAULT_ATTR = 8'h07,
  parameter logic [7:0] FILL_CHAR    = 8'h20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic [10:0] cursor,
  output logic [16:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);
  localparam logic [16:0] BASE = 17'h0F000;

  typedef enum logic [3:0] {
    CLEAR, IDLE, PUT_C, PUT_A, CTRL, SCR_RD, SCR_WAIT, SCR_WR, FILL
`ifdef CONSOLE_ATTR_ESC_EN
    , ESC
`endif
  } state_t;

  state_t      state;
  logic [7:0]  attr;
  logic [7:0]  cmd;
  logic [11:0] idx;
  logic [10:0] row, row_start, col, cursor_inc;
  logic        ctrl_code;

  always_comb begin
    row        = cursor / 11'd80;
    row_start  = row * 11'd80;
    col        = cursor - row_start;
    cursor_inc = cursor + 11'd1;
    ctrl_code  = (in_data == 8'h0D) || (in_data == 8'h0A) ||
                 (in_data == 8'h08) || (in_data == 8'h0C);
  end

`ifdef CONSOLE_ATTR_ESC_EN
  assign in_ready = (state == IDLE) || (state == ESC);
`else
  assign in_ready = (state == IDLE);
`endif
  assign busy = (state != IDLE);

  // Memory outputs are loaded on the edge that enters a state, so each
  // state's access is visible on the bus during that state's own cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= CLEAR;
      cursor      <= 11'd0;
      attr        <= DEFAULT_ATTR;
      cmd         <= 8'd0;
      idx         <= 12'd0;
      mem_we      <= 1'b0;
      mem_address <= BASE;
      mem_wdata   <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        CLEAR: begin
          if (idx == 12'd4000) begin
            state <= IDLE;
          end else begin
            mem_we      <= 1'b1;
            mem_address <= BASE + {5'd0, idx};
            mem_wdata   <= idx[0] ? attr : FILL_CHAR;
            idx         <= idx + 12'd1;
          end
        end
        IDLE: begin
          if (in_valid) begin
            if (ctrl_code) begin
              cmd   <= in_data;
              state <= CTRL;
            end else begin
              state       <= PUT_C;
              mem_we      <= 1'b1;
              mem_address <= BASE + {5'd0, cursor, 1'b0};
              mem_wdata   <= in_data;
            end
`ifdef CONSOLE_ATTR_ESC_EN
            if (in_data == 8'h1B) begin
              state  <= ESC;
              mem_we <= 1'b0;
            end
`endif
          end
        end
        PUT_C: begin
          state       <= PUT_A;
          mem_we      <= 1'b1;
          mem_address <= mem_address + 17'd1;
          mem_wdata   <= attr;
        end
        PUT_A: begin
          if (cursor_inc == 11'd2000) begin
            cursor      <= 11'd1920;
            idx         <= 12'd0;
            mem_address <= BASE + 17'd160;
            state       <= SCR_RD;
          end else begin
            cursor <= cursor_inc;
            state  <= IDLE;
          end
        end
        CTRL: begin
          state <= IDLE;
          case (cmd)
            8'h0D: cursor <= row_start;
            8'h0A: begin
              if (row == 11'd24) begin
                cursor      <= 11'd1920;
                idx         <= 12'd0;
                mem_address <= BASE + 17'd160;
                state       <= SCR_RD;
              end else begin
                cursor <= row_start + 11'd80;
              end
            end
            8'h08: if (col != 11'd0) cursor <= cursor - 11'd1;
            default: begin
              cursor <= 11'd0;
              idx    <= 12'd0;
              state  <= CLEAR;
            end
          endcase
        end
        SCR_RD: state <= SCR_WAIT;
        SCR_WAIT: begin
          state       <= SCR_WR;
          mem_we      <= 1'b1;
          mem_address <= BASE + {5'd0, idx};
          mem_wdata   <= mem_rdata;
        end
        SCR_WR: begin
          if (idx == 12'd3839) begin
            idx         <= 12'd3840;
            state       <= FILL;
            mem_we      <= 1'b1;
            mem_address <= BASE + 17'd3840;
            mem_wdata   <= FILL_CHAR;
          end else begin
            idx         <= idx + 12'd1;
            state       <= SCR_RD;
            mem_address <= BASE + 17'd161 + {5'd0, idx};
          end
        end
        FILL: begin
          if (idx == 12'd3999) begin
            state <= IDLE;
          end else begin
            idx         <= idx + 12'd1;
            mem_we      <= 1'b1;
            mem_address <= mem_address + 17'd1;
            mem_wdata   <= idx[0] ? FILL_CHAR : attr;
          end
        end
`ifdef CONSOLE_ATTR_ESC_EN
        ESC: begin
          if (in_valid) begin
            attr  <= in_data;
            state <= IDLE;
          end
        end
`endif
        default: begin
          idx   <= 12'd0;
          state <= CLEAR;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_text_console.sv
// tb/tb_text_console.sv - scoreboard bench for text_console against a cell-level buffer model
module tb_text_console;
  localparam int BASE = 'h0F000;
  localparam int SCROLL_CYCLES = 3840 * 3 + 160;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, busy, mem_we;
  logic [10:0] cursor;
  logic [16:0] mem_address;
  logic [7:0]  mem_wdata, mem_rdata;

  text_console dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .cursor(cursor), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Video RAM: write on the edge, read data registered once so it is
  // sampled two edges after the address is launched.
  logic [7:0] ram [0:3999];
  logic [7:0] rd_q = 8'd0;
  int         ram_off;
  assign ram_off   = int'(mem_address) - BASE;
  assign mem_rdata = rd_q;
  always @(posedge clock) begin
    if (ram_off >= 0 && ram_off < 4000) begin
      if (mem_we) ram[ram_off] <= mem_wdata;
      rd_q <= ram[ram_off];
    end
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [24:0] exp_q[$];
  logic [24:0] exp_e;
  logic [7:0]  ref_mem [0:3999];
  int          m_cur;
  logic [7:0]  m_attr;
  bit          m_esc;
  logic [7:0]  row1 [0:79];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push(input int off, input logic [7:0] d);
    logic [16:0] a;
    a = 17'(BASE + off);
    exp_q.push_back({a, d});
    ref_mem[off] = d;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4000; i++) push(i, (i % 2 == 1) ? m_attr : 8'h20);
  endfunction

  function automatic void model_scroll();
    for (int k = 0; k < 3840; k++) push(k, ref_mem[160 + k]);
    for (int k = 3840; k < 4000; k++) push(k, (k % 2 == 1) ? m_attr : 8'h20);
  endfunction

  // Applies one byte to the model; returns cycles from the transfer edge until ready again.
  function automatic int model_byte(input logic [7:0] b);
    int lat;
`ifdef CONSOLE_ATTR_ESC_EN
    if (m_esc) begin
      m_attr = b;
      m_esc = 1'b0;
      return 0;
    end
    if (b == 8'h1B) begin
      m_esc = 1'b1;
      return 0;
    end
`endif
    lat = 1;
    case (b)
      8'h0D: m_cur = (m_cur / 80) * 80;
      8'h0A: begin
        if (m_cur / 80 == 24) begin
          m_cur = 1920;
          model_scroll();
          lat = 1 + SCROLL_CYCLES;
        end else begin
          m_cur = (m_cur / 80 + 1) * 80;
        end
      end
      8'h08: if (m_cur % 80 != 0) m_cur = m_cur - 1;
      8'h0C: begin
        m_cur = 0;
        model_clear();
        lat = 1 + 4001;
      end
      default: begin
        push(2 * m_cur, b);
        push(2 * m_cur + 1, m_attr);
        m_cur = m_cur + 1;
        lat = 2;
        if (m_cur == 2000) begin
          m_cur = 1920;
          model_scroll();
          lat = 2 + SCROLL_CYCLES;
        end
      end
    endcase
    return lat;
  endfunction

  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", int'(mem_address), -1);
      end else begin
        exp_e = exp_q.pop_front();
        check("write_addr", int'(mem_address), int'(exp_e[24:8]));
        check("write_data", int'(mem_wdata), int'(exp_e[7:0]));
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 20000) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic send_raw(input logic [7:0] b, output int lat);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    wait_ready(n);
    check("accept_ready", int'(in_ready), 1);
    lat = model_byte(b);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int lat, n;
    send_raw(b, lat);
    wait_ready(n);
    check("latency", n, lat);
  endtask

  task automatic do_reset();
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    exp_q.delete();
    m_cur  = 0;
    m_attr = 8'h07;
    m_esc  = 1'b0;
    model_clear();
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_address", int'(mem_address), BASE);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_cursor", int'(cursor), 0);
    reset = 1'b0;
    wait_ready(n);
    check("clear_cycles", n, 4001);
    check("clear_drained", exp_q.size(), 0);
    check("idle_cursor", int'(cursor), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, bad;
    logic [7:0] c;
    do_reset();

    send(8'h41);
    check("cursor_after_A", int'(cursor), 1);
    send(8'h42);
    check("cursor_after_B", int'(cursor), 2);
    send(8'h0D);
    check("cursor_after_CR", int'(cursor), 0);
    send(8'h08);
    check("cursor_after_BS_col0", int'(cursor), 0);

    send(8'h0C);
    check("cursor_after_FF", int'(cursor), 0);
    send(8'h0A);
    check("cursor_after_LF", int'(cursor), 80);
    for (int i = 0; i < 80; i++) begin
      c = 8'($urandom_range(33, 126));
      row1[i] = c;
      send(c);
    end
    for (int i = 0; i < 1839; i++) send(8'($urandom_range(32, 126)));
    check("cursor_at_1999", int'(cursor), 1999);
    send_raw(8'h5A, lat);
    repeat (3) @(posedge clock);
    #1;
    check("scroll_cursor", int'(cursor), 1920);
    check("scroll_busy", int'(busy), 1);
    wait_ready(n);
    check("scroll_latency", n + 3, 2 + SCROLL_CYCLES);
    for (int i = 0; i < 80; i++) begin
      check("scrolled_row0_char", int'(ram[2 * i]), int'(row1[i]));
      check("scrolled_row0_attr", int'(ram[2 * i + 1]), 'h07);
    end
    bad = 0;
    for (int i = 3840; i < 4000; i++)
      if (ram[i] != ((i % 2 == 1) ? 8'h07 : 8'h20)) bad++;
    check("scroll_fill_bad_bytes", bad, 0);

    send(8'h0C);
    send(8'h1B);
    send(8'h1E);
    send(8'h51);
`ifdef CONSOLE_ATTR_ESC_EN
    check("esc_q_char", int'(ram[0]), 'h51);
    check("esc_q_attr", int'(ram[1]), 'h1E);
    check("esc_cursor", int'(cursor), 1);
`else
    check("esc_glyph", int'(ram[0]), 'h1B);
    check("esc_q_char", int'(ram[4]), 'h51);
    check("esc_q_attr", int'(ram[5]), 'h07);
    check("esc_cursor", int'(cursor), 3);
`endif

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: c = 8'h0D;
        1: c = (m_cur / 80 == 24) ? 8'h0D : 8'h0A;
        2: c = 8'h08;
        default: c = 8'($urandom_range(32, 126));
      endcase
      send(c);
      check("random_cursor", int'(cursor), m_cur);
    end

    send(8'h0C);
    for (int i = 0; i < 24; i++) send(8'h0A);
    check("cursor_row24", int'(cursor), 1920);
    send_raw(8'h0A, lat);
    repeat (500) @(posedge clock);
    #1;
    check("midscroll_busy", int'(busy), 1);
    do_reset();

    bad = 0;
    for (int i = 0; i < 4000; i++)
      if (ram[i] != ref_mem[i]) bad++;
    check("final_image_bad_bytes", bad, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
